// File: rtl/perspective_divide_seq_if.sv
// Bundles the signals of the perspective-divide sequencer: the vertex input handshake,
// the operand/quotient path to and from fixed_divide, and the NDC result handshake.
interface perspective_divide_seq_if;
   logic               vtx_valid_in;
   logic               vtx_ready_out;
   logic signed [24:0] x_in;
   logic signed [24:0] y_in;
   logic signed [24:0] z_in;
   logic signed [24:0] w_in;
   logic [23:0]        div_dividend_out;
   logic [23:0]        div_divisor_out;
   logic [25:0]        div_quotient_in;
   logic               ndc_valid_out;
   logic               ndc_ready_in;
   logic signed [26:0] ndc_x_out;
   logic signed [26:0] ndc_y_out;
   logic signed [26:0] ndc_z_out;
   logic               div_zero_out;

   modport slave (
      input  vtx_valid_in, x_in, y_in, z_in, w_in, div_quotient_in, ndc_ready_in,
      output vtx_ready_out, div_dividend_out, div_divisor_out,
             ndc_valid_out, ndc_x_out, ndc_y_out, ndc_z_out, div_zero_out
   );

   modport master (
      output vtx_valid_in, x_in, y_in, z_in, w_in, div_quotient_in, ndc_ready_in,
      input  vtx_ready_out, div_dividend_out, div_divisor_out,
             ndc_valid_out, ndc_x_out, ndc_y_out, ndc_z_out, div_zero_out
   );
endinterface

// File: rtl/perspective_divide_seq.sv
// Perspective-divide sequencer: feeds x/w, y/w, z/w magnitudes into the unsigned
// pipelined fixed_divide, then re-applies signs and w == 0 saturation to build the NDC triple.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | ready for a vertex
// ST_ISSUE | three cycles driving |x|,|y|,|z| over |w| into the divider
// ST_WAIT  | quotients in flight; leave when the lane-z tag exits
// ST_OUT   | NDC triple valid, held until downstream accepts
module perspective_divide_seq #(
   parameter int          DIV_LATENCY = 16,
   parameter logic [25:0] Q_MAX       = 26'h3FFFFFF
) (
   input logic                    clk_in,
   input logic                    rst_n_in,
   perspective_divide_seq_if.slave bus
);
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_OUT   = 2'd3;

   localparam logic [1:0] LANE_X = 2'd0;
   localparam logic [1:0] LANE_Y = 2'd1;
   localparam logic [1:0] LANE_Z = 2'd2;

   logic [1:0]         state;
   logic [1:0]         issue_lane;
   logic signed [24:0] x_r, y_r, z_r, w_r;
   logic signed [26:0] ndc_x_r, ndc_y_r, ndc_z_r;
   logic               div_zero_r;

   logic [DIV_LATENCY-1:0] tag_valid;
   logic [DIV_LATENCY-1:0] tag_sign;
   logic [1:0]             tag_lane [DIV_LATENCY];

   // -2^24 has no 24-bit magnitude, so it saturates to the largest one.
   function automatic logic [23:0] magnitude(input logic signed [24:0] v);
      logic [24:0] neg;
      neg = 25'(-v);
      if (!v[24])
         return v[23:0];
      else if (neg[24])
         return 24'hFFFFFF;
      else
         return neg[23:0];
   endfunction

   logic signed [24:0] issue_num;
   logic               issue_active;
   logic               issue_sign;

   always_comb begin
      issue_num = z_r;
      case (issue_lane)
         LANE_X:  issue_num = x_r;
         LANE_Y:  issue_num = y_r;
         default: issue_num = z_r;
      endcase
   end

   assign issue_active = (state == ST_ISSUE);
   assign issue_sign   = issue_num[24] ^ w_r[24];

   assign bus.div_dividend_out = issue_active ? magnitude(issue_num) : 24'd0;
   assign bus.div_divisor_out  = issue_active ? magnitude(w_r) : 24'd0;

   logic               exit_valid;
   logic [1:0]         exit_lane;
   logic               exit_sign;
   logic signed [24:0] exit_num;
   logic               w_zero;
   logic [25:0]        exit_mag;
   logic [26:0]        exit_result;

   assign exit_valid = tag_valid[DIV_LATENCY-1];
   assign exit_lane  = tag_lane[DIV_LATENCY-1];
   assign exit_sign  = tag_sign[DIV_LATENCY-1];
   assign w_zero     = (w_r == 25'sd0);

   always_comb begin
      exit_num = z_r;
      case (exit_lane)
         LANE_X:  exit_num = x_r;
         LANE_Y:  exit_num = y_r;
         default: exit_num = z_r;
      endcase
   end

   // Vertex registers stay put until the next accept, so w == 0 substitution can read them at exit.
   always_comb begin
      exit_mag = bus.div_quotient_in;
      if (w_zero)
         exit_mag = (exit_num == 25'sd0) ? 26'd0 : Q_MAX;
      exit_result = exit_sign ? 27'(-{1'b0, exit_mag}) : {1'b0, exit_mag};
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         tag_valid <= '0;
         tag_sign  <= '0;
         for (int i = 0; i < DIV_LATENCY; i++)
            tag_lane[i] <= 2'd0;
      end else begin
         tag_valid[0] <= issue_active;
         tag_sign[0]  <= issue_active & issue_sign;
         tag_lane[0]  <= issue_active ? issue_lane : 2'd0;
         for (int i = 1; i < DIV_LATENCY; i++) begin
            tag_valid[i] <= tag_valid[i-1];
            tag_sign[i]  <= tag_sign[i-1];
            tag_lane[i]  <= tag_lane[i-1];
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state      <= ST_IDLE;
         issue_lane <= LANE_X;
         x_r        <= '0;
         y_r        <= '0;
         z_r        <= '0;
         w_r        <= '0;
         ndc_x_r    <= '0;
         ndc_y_r    <= '0;
         ndc_z_r    <= '0;
         div_zero_r <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.vtx_valid_in) begin
                  x_r        <= bus.x_in;
                  y_r        <= bus.y_in;
                  z_r        <= bus.z_in;
                  w_r        <= bus.w_in;
                  issue_lane <= LANE_X;
                  state      <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (issue_lane == LANE_Z) begin
                  issue_lane <= LANE_X;
                  state      <= ST_WAIT;
               end else begin
                  issue_lane <= issue_lane + 2'd1;
               end
            end
            ST_WAIT: begin
               if (exit_valid && exit_lane == LANE_Z)
                  state <= ST_OUT;
            end
            default: begin
               if (bus.ndc_ready_in)
                  state <= ST_IDLE;
            end
         endcase

         if (exit_valid) begin
            case (exit_lane)
               LANE_X:  ndc_x_r <= exit_result;
               LANE_Y:  ndc_y_r <= exit_result;
               default: begin
                  ndc_z_r    <= exit_result;
                  div_zero_r <= w_zero;
               end
            endcase
         end
      end
   end

   assign bus.vtx_ready_out = (state == ST_IDLE);
   assign bus.ndc_valid_out = (state == ST_OUT);
   assign bus.ndc_x_out     = ndc_x_r;
   assign bus.ndc_y_out     = ndc_y_r;
   assign bus.ndc_z_out     = ndc_z_r;
   assign bus.div_zero_out  = div_zero_r;
endmodule

// File: tb/tb_perspective_divide_seq.sv
// Bench for perspective_divide_seq: a latency-accurate fixed_divide model feeds quotients back,
// and each vertex result is compared with signed arithmetic computed directly from x, y, z, w.
module tb_perspective_divide_seq;
   localparam int          L     = 16;
   localparam logic [25:0] QMAX  = 26'h3FFFFFF;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_pass;

   perspective_divide_seq_if bus();

   perspective_divide_seq #(.DIV_LATENCY(L), .Q_MAX(QMAX)) dut (
      .clk_in   (clk),
      .rst_n_in (rst_n),
      .bus      (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // fixed_divide model: operands seen in cycle t produce the quotient during cycle t+L
   logic [23:0] pa [L];
   logic [23:0] pb [L];

   always @(posedge clk) begin
      pa[0] <= bus.div_dividend_out;
      pb[0] <= bus.div_divisor_out;
      for (int i = 1; i < L; i++) begin
         pa[i] <= pa[i-1];
         pb[i] <= pb[i-1];
      end
   end

   always_comb begin
      logic [63:0] q;
      q = 64'd0;
      if (pb[L-1] != 24'd0) q = ({40'd0, pa[L-1]} << 16) / {40'd0, pb[L-1]};
      if (q > {38'd0, QMAX}) q = {38'd0, QMAX};
      bus.div_quotient_in = q[25:0];
   end

   function automatic logic [23:0] mag_ref(input logic signed [24:0] v);
      longint t;
      t = v;
      if (t < 0) t = -t;
      if (t > 64'hFFFFFF) t = 64'hFFFFFF;
      return t[23:0];
   endfunction

   function automatic logic [26:0] ndc_ref(input logic signed [24:0] num, input logic signed [24:0] w);
      longint n, d, q;
      logic   neg;
      logic [63:0] r;
      n = num;
      d = w;
      if (d == 0) begin
         if (n == 0) return 27'd0;
         q   = longint'(QMAX);
         neg = (n < 0);
      end else begin
         q = (longint'(mag_ref(num)) * 65536) / longint'(mag_ref(w));
         if (q > longint'(QMAX)) q = longint'(QMAX);
         neg = ((n < 0) != (d < 0));
      end
      r = neg ? 64'(-q) : 64'(q);
      return r[26:0];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_vertex(input logic signed [24:0] x, input logic signed [24:0] y,
                            input logic signed [24:0] z, input logic signed [24:0] w,
                            input int hold, input bit keep_valid, input bit expect_immediate,
                            input string name);
      logic signed [24:0] nums [3];
      logic [26:0]        ex, ey, ez;
      int                 cnt;
      int                 lat;
      nums[0] = x; nums[1] = y; nums[2] = z;
      ex = ndc_ref(x, w);
      ey = ndc_ref(y, w);
      ez = ndc_ref(z, w);
      bus.x_in = x; bus.y_in = y; bus.z_in = z; bus.w_in = w;
      bus.vtx_valid_in = 1'b1;
      bus.ndc_ready_in = 1'b0;
      cnt = 0;
      while (!bus.vtx_ready_out && cnt < 200) begin
         tick();
         cnt++;
      end
      if (expect_immediate) begin
         n_checks++;
         if (cnt !== 0) $display("FAIL %s accept_wait: got %0d cycles, want 0", name, cnt);
         else n_pass++;
      end
      tick();
      if (!keep_valid) bus.vtx_valid_in = 1'b0;
      for (int lane = 0; lane < 3; lane++) begin
         n_checks++;
         if (bus.div_dividend_out !== mag_ref(nums[lane]) || bus.div_divisor_out !== mag_ref(w) ||
             bus.vtx_ready_out !== 1'b0)
            $display("FAIL %s issue_lane%0d: got a=%h b=%h rdy=%b, want a=%h b=%h rdy=0", name, lane,
                     bus.div_dividend_out, bus.div_divisor_out, bus.vtx_ready_out,
                     mag_ref(nums[lane]), mag_ref(w));
         else n_pass++;
         tick();
      end
      lat = 4;
      while (!bus.ndc_valid_out && lat < L + 60) begin
         tick();
         lat++;
      end
      n_checks++;
      if (lat !== L + 4) $display("FAIL %s latency: got %0d, want %0d", name, lat, L + 4);
      else n_pass++;
      n_checks++;
      if (bus.ndc_x_out !== ex || bus.ndc_y_out !== ey || bus.ndc_z_out !== ez ||
          bus.div_zero_out !== (w == 25'sd0))
         $display("FAIL %s result: got %h %h %h dz=%b, want %h %h %h dz=%b", name,
                  bus.ndc_x_out, bus.ndc_y_out, bus.ndc_z_out, bus.div_zero_out,
                  ex, ey, ez, (w == 25'sd0));
      else n_pass++;
      for (int h = 0; h < hold; h++) begin
         tick();
         n_checks++;
         if (bus.ndc_valid_out !== 1'b1 || bus.vtx_ready_out !== 1'b0 || bus.ndc_x_out !== ex ||
             bus.ndc_y_out !== ey || bus.ndc_z_out !== ez)
            $display("FAIL %s hold%0d: got v=%b rdy=%b %h %h %h, want v=1 rdy=0 %h %h %h", name, h,
                     bus.ndc_valid_out, bus.vtx_ready_out, bus.ndc_x_out, bus.ndc_y_out,
                     bus.ndc_z_out, ex, ey, ez);
         else n_pass++;
      end
      bus.ndc_ready_in = 1'b1;
      tick();
      bus.ndc_ready_in = 1'b0;
      n_checks++;
      if (bus.ndc_valid_out !== 1'b0 || bus.vtx_ready_out !== 1'b1)
         $display("FAIL %s handshake: got v=%b rdy=%b, want v=0 rdy=1", name,
                  bus.ndc_valid_out, bus.vtx_ready_out);
      else n_pass++;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.vtx_valid_in = 1'b0;
      bus.ndc_ready_in = 1'b0;
      bus.x_in = '0; bus.y_in = '0; bus.z_in = '0; bus.w_in = '0;
      repeat (3) tick();
      n_checks++;
      if (bus.vtx_ready_out !== 1'b1 || bus.ndc_valid_out !== 1'b0 || bus.div_zero_out !== 1'b0 ||
          bus.ndc_x_out !== 27'd0 || bus.ndc_y_out !== 27'd0 || bus.ndc_z_out !== 27'd0 ||
          bus.div_dividend_out !== 24'd0 || bus.div_divisor_out !== 24'd0)
         $display("FAIL reset_state: got rdy=%b v=%b dz=%b x=%h a=%h b=%h, want 1 0 0 0 0 0",
                  bus.vtx_ready_out, bus.ndc_valid_out, bus.div_zero_out, bus.ndc_x_out,
                  bus.div_dividend_out, bus.div_divisor_out);
      else n_pass++;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      do_vertex(25'sh010000, 25'sh020000, 25'sh008000, 25'sh020000, 0, 1'b0, 1'b0, "basic");
   endtask

   task automatic test_signs();
      do_vertex(-25'sh010000, 25'sh010000, -25'sh010000, -25'sh020000, 0, 1'b0, 1'b0, "signs");
   endtask

   task automatic test_div_zero();
      do_vertex(25'sd5, -25'sd5, 25'sd0, 25'sd0, 1, 1'b0, 1'b0, "div_zero");
   endtask

   task automatic test_backpressure();
      do_vertex(25'sh123456, -25'sh0ABCDE, 25'sh000777, 25'sh040000, 10, 1'b0, 1'b0, "backpressure");
   endtask

   task automatic test_back_to_back();
      do_vertex(25'sh0F0000, -25'sh030000, 25'sh001234, -25'sh100000, 2, 1'b1, 1'b0, "b2b_first");
      do_vertex(25'sh1000000, 25'sh000003, -25'sh000002, 25'sd1, 0, 1'b0, 1'b1, "b2b_clamp");
   endtask

   task automatic test_random();
      for (int i = 0; i < 8; i++) begin
         logic [31:0] rx, ry, rz, rw;
         logic signed [24:0] w;
         rx = $urandom; ry = $urandom; rz = $urandom; rw = $urandom;
         w = rw[24:0];
         if (i == 3) w = 25'sd0;
         if (i == 5) w = 25'(rw[10:0]);
         do_vertex(rx[24:0], ry[24:0], rz[24:0], w, int'($urandom_range(0, 3)), 1'b0, 1'b0, "random");
      end
   endtask

   task automatic test_reset_mid();
      int stray;
      bus.x_in = 25'sh011111; bus.y_in = 25'sh022222; bus.z_in = 25'sh033333; bus.w_in = 25'sh010000;
      bus.vtx_valid_in = 1'b1;
      tick();
      bus.vtx_valid_in = 1'b0;
      repeat (6) tick();
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (bus.vtx_ready_out !== 1'b1 || bus.ndc_valid_out !== 1'b0 || bus.div_zero_out !== 1'b0 ||
          bus.ndc_x_out !== 27'd0 || bus.ndc_y_out !== 27'd0 || bus.ndc_z_out !== 27'd0 ||
          bus.div_dividend_out !== 24'd0 || bus.div_divisor_out !== 24'd0)
         $display("FAIL mid_reset_state: got rdy=%b v=%b dz=%b x=%h y=%h z=%h, want 1 0 0 0 0 0",
                  bus.vtx_ready_out, bus.ndc_valid_out, bus.div_zero_out,
                  bus.ndc_x_out, bus.ndc_y_out, bus.ndc_z_out);
      else n_pass++;
      repeat (2) tick();
      rst_n = 1'b1;
      bus.ndc_ready_in = 1'b1;
      stray = 0;
      for (int c = 0; c < 2 * L; c++) begin
         tick();
         if (bus.ndc_valid_out) stray++;
      end
      bus.ndc_ready_in = 1'b0;
      n_checks++;
      if (stray !== 0) $display("FAIL mid_reset_stray: got %0d valid cycles, want 0", stray);
      else n_pass++;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks = 0;
      n_pass   = 0;
      test_reset();
      test_basic();
      test_signs();
      test_div_zero();
      test_backpressure();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/perspective_divide_seq.md
Name: perspective_divide_seq

Overview:
- Perspective-divide sequencer for the vertex path: accepts one clip-space vertex (x, y, z, w), issues x/w, y/w and z/w on three consecutive cycles into the shared unsigned pipelined fixed_divide unit, collects the three quotients and emits one signed NDC triple.
- Sits directly upstream of fixed_divide, driving its dividend/divisor inputs, and directly downstream of it, consuming its quotient output.
- Owns all sign handling and divide-by-zero handling, because fixed_divide is unsigned and carries no valid signal.

Parameters:
DIV_LATENCY, 16, cycles from operands presented on div_dividend_out/div_divisor_out to matching quotient on div_quotient_in; must equal fixed_divide pipeline depth, >=1
Q_MAX, 26'h3FFFFFF, saturated quotient magnitude substituted when w == 0

Ports:
clk_in  input  1  system clock
rst_n_in  input  1  asynchronous active-low reset
vtx_valid_in  input  1  vertex present
vtx_ready_out  output  1  block can accept vertex
x_in  input  25  signed two's-complement x
y_in  input  25  signed y
z_in  input  25  signed z
w_in  input  25  signed w
div_dividend_out  output  24  unsigned magnitude to fixed_divide dividend_in
div_divisor_out  output  24  unsigned magnitude to fixed_divide divisor_in
div_quotient_in  input  26  unsigned quotient from fixed_divide quotient_out
ndc_valid_out  output  1  result triple valid
ndc_ready_in  input  1  downstream accepts result
ndc_x_out  output  27  signed x/w
ndc_y_out  output  27  signed y/w
ndc_z_out  output  27  signed z/w
div_zero_out  output  1  result produced with w == 0 (qualified by ndc_valid_out)

Behaviour:
- Reset (async assert, sync deassert): state IDLE, vtx_ready_out=1, ndc_valid_out=0, ndc_* = 0, div_zero_out=0, div_*_out=0, tag pipe cleared.
- Mid-operation reset: in-flight divider results are discarded; no result is emitted after reset release.
- FSM states: IDLE -> ISSUE -> WAIT -> OUT -> IDLE.
- IDLE:
  - vtx_ready_out=1.
  - On vtx_valid_in && vtx_ready_out, latch x/y/z/w; go ISSUE (cycle A).
  - At most one vertex in flight.
- ISSUE: three cycles, A+1, A+2, A+3. Drive div_dividend_out = |x|, |y|, |z| in that order; div_divisor_out = |w| on all three.
- Magnitude rule: |v| = v<0 ? -v : v. Input -2^24 clamps to 24'hFFFFFF.
- Sign bit per lane: sign(num) XOR sign(w).
- Tag pipe:
  - A DIV_LATENCY-deep shift register of {valid, lane[1:0], sign} is pushed each ISSUE cycle.
  - On tag exit, capture div_quotient_in into the lane's register.
  - Negate when the sign bit is set; output = 27-bit two's complement of zero-extended quotient.
- Divide by zero: when w == 0, the captured quotient is replaced by Q_MAX with the numerator's sign (0 numerator -> 0), and div_zero_out=1 with the result.
- WAIT: idle until the lane-z tag exits (cycle A+3+DIV_LATENCY); go OUT next cycle.
- OUT:
  - ndc_valid_out=1 from cycle A+4+DIV_LATENCY.
  - Outputs held stable while ndc_ready_in=0.
  - On ndc_valid_out && ndc_ready_in, drop valid and go IDLE. vtx_ready_out rises the following cycle.
- Throughput: one vertex per DIV_LATENCY+5 cycles minimum. vtx_ready_out=0 in ISSUE, WAIT and OUT.
- div_*_out are don't-care outside ISSUE but driven to 0 for waveform clarity.

Test Plan:
Bench drives div_quotient_in from a DIV_LATENCY-deep model of fixed_divide: q = min(floor(a*2^16/b), 2^26-1), b != 0.
1. Reset, then vertex x=0x010000, y=0x020000, z=0x008000, w=0x020000, ndc_ready_in=1 -> ndc = 0x008000, 0x010000, 0x004000; ndc_valid_out rises exactly DIV_LATENCY+4 cycles after accept; div_zero_out=0.
2. Signs: x=-0x010000, y=0x010000, z=-0x010000, w=-0x020000 -> ndc = 0x008000, -0x008000, 0x008000.
3. w=0, x=5, y=-5, z=0 -> ndc = 0x3FFFFFF, -0x3FFFFFF, 0; div_zero_out=1.
4. Back-pressure: hold ndc_ready_in=0 for 10 cycles -> outputs stable, vtx_ready_out=0; release -> one handshake, vtx_ready_out=1 next cycle.
5. Back-to-back: vtx_valid_in held with two vertices -> second accepted only after first result consumed, with correct per-lane ordering. Clamp case x=-2^24, w=1 gives dividend 0xFFFFFF.
6. Assert rst_n_in during WAIT -> outputs return to reset values immediately; after release no stray ndc_valid_out within 2*DIV_LATENCY cycles.
